demux_1_4_stream: RTL and testbench



---
 rtl/demux_1_4_stream.sv | 89 ++++++++
 tb/tb_demux_1_4_stream.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_4_stream.sv
// Registered 1:4 valid/ready stream demultiplexer with one holding register per channel.
// Optional broadcast to all four channels is enabled by defining DEMUX_1_4_BROADCAST_EN.
module demux_1_4_stream #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
`ifdef DEMUX_1_4_BROADCAST_EN
    input  logic             in_bcast,
`endif
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [2:0]       occupancy
);

    logic [3:0]            valid_q, valid_d;
    logic [3:0][WIDTH-1:0] data_q, data_d;
    logic [2:0]            occupancy_q, occupancy_d;

    logic [3:0] chan_free;
    logic [3:0] load;
    logic [3:0] out_fire;
    logic       bcast;
    logic       in_fire;
    logic [2:0] n_fill;
    logic [2:0] n_drain;

`ifdef DEMUX_1_4_BROADCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // A channel can take a word if it is empty or its current word leaves this cycle.
    assign chan_free = ~valid_q | out_ready;
    assign out_fire  = valid_q & out_ready;
    assign in_ready  = bcast ? (&chan_free) : chan_free[in_sel];
    assign in_fire   = in_valid & in_ready;

    always_comb begin
        load        = 4'b0000;
        valid_d     = valid_q;
        data_d      = data_q;
        n_fill      = 3'd0;
        n_drain     = 3'd0;
        for (int i = 0; i < 4; i++) begin
            load[i]    = in_fire & (bcast | (in_sel == 2'(i)));
            valid_d[i] = load[i] | (valid_q[i] & ~out_fire[i]);
            if (load[i]) begin
                data_d[i] = in_data;
            end
            if (load[i] && !valid_q[i]) begin
                n_fill = n_fill + 3'd1;
            end
            if (out_fire[i] && !load[i]) begin
                n_drain = n_drain + 3'd1;
            end
        end
        occupancy_d = occupancy_q + n_fill - n_drain;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 4'b0000;
            data_q      <= '0;
            occupancy_q <= 3'd0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed self-checking bench for demux_1_4_stream; broadcast vectors run only when
// DEMUX_1_4_BROADCAST_EN is defined.
module tb_demux_1_4_stream;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
`ifdef DEMUX_1_4_BROADCAST_EN
    logic             in_bcast;
`endif
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [2:0]       occupancy;

    int checks = 0;
    int errors = 0;

    demux_1_4_stream #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
`ifdef DEMUX_1_4_BROADCAST_EN
        .in_bcast  (in_bcast),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] fill_data [4];

    initial begin
        fill_data[0] = 4'hA;
        fill_data[1] = 4'hB;
        fill_data[2] = 4'hC;
        fill_data[3] = 4'hD;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 2'd0;
        out_ready = 4'b0000;
`ifdef DEMUX_1_4_BROADCAST_EN
        in_bcast  = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        step();

        check_eq("rst_valid", 32'(out_valid), 32'h0);
        check_eq("rst_d0", 32'(out_data0), 32'h0);
        check_eq("rst_d1", 32'(out_data1), 32'h0);
        check_eq("rst_d2", 32'(out_data2), 32'h0);
        check_eq("rst_d3", 32'(out_data3), 32'h0);
        check_eq("rst_occ", 32'(occupancy), 32'h0);
        check_eq("rst_ready", 32'(in_ready), 32'h1);

        // Fill all four channels with consumers stalled.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = fill_data[k];
            #1;
            check_eq("fill_ready", 32'(in_ready), 32'h1);
            step();
            check_eq("fill_occ", 32'(occupancy), 32'(k + 1));
        end
        in_valid = 1'b0;
        #1;
        check_eq("fill_valid", 32'(out_valid), 32'hF);
        check_eq("fill_d0", 32'(out_data0), 32'hA);
        check_eq("fill_d1", 32'(out_data1), 32'hB);
        check_eq("fill_d2", 32'(out_data2), 32'hC);
        check_eq("fill_d3", 32'(out_data3), 32'hD);
        for (int k = 0; k < 4; k++) begin
            in_sel = 2'(k);
            #1;
            check_eq("full_ready", 32'(in_ready), 32'h0);
        end

        // Drain channel 0; its data register keeps the old word.
        out_ready = 4'b0001;
        step();
        out_ready = 4'b0000;
        check_eq("drain_valid", 32'(out_valid), 32'hE);
        check_eq("drain_occ", 32'(occupancy), 32'h3);
        check_eq("drain_hold", 32'(out_data0), 32'hA);

        // Stalled full channel 2 refuses a word.
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 4'h5;
        #1;
        check_eq("stall_ready", 32'(in_ready), 32'h0);
        step();
        check_eq("stall_d2", 32'(out_data2), 32'hC);
        check_eq("stall_valid", 32'(out_valid), 32'hE);
        check_eq("stall_occ", 32'(occupancy), 32'h3);

        // Empty channel 0 still accepts.
        in_sel  = 2'd0;
        in_data = 4'h6;
        #1;
        check_eq("other_ready", 32'(in_ready), 32'h1);
        step();
        check_eq("other_d0", 32'(out_data0), 32'h6);
        check_eq("other_valid", 32'(out_valid), 32'hF);
        check_eq("other_occ", 32'(occupancy), 32'h4);

        // Put 4'h3 into channel 1.
        in_valid  = 1'b0;
        out_ready = 4'b0010;
        step();
        check_eq("c1_drain_occ", 32'(occupancy), 32'h3);
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 4'h3;
        step();
        check_eq("c1_load_d1", 32'(out_data1), 32'h3);
        check_eq("c1_load_occ", 32'(occupancy), 32'h4);

        // Pass-through on channel 1: consumer takes 3, register loads 7.
        out_ready = 4'b0010;
        in_data   = 4'h7;
        #1;
        check_eq("pt_ready", 32'(in_ready), 32'h1);
        check_eq("pt_old_word", 32'(out_data1), 32'h3);
        step();
        check_eq("pt_d1", 32'(out_data1), 32'h7);
        check_eq("pt_valid", 32'(out_valid), 32'hF);
        check_eq("pt_occ", 32'(occupancy), 32'h4);

        // Channel 0 drains while channel 1 passes through.
        out_ready = 4'b0011;
        in_data   = 4'h8;
        step();
        check_eq("mix_valid", 32'(out_valid), 32'hE);
        check_eq("mix_d1", 32'(out_data1), 32'h8);
        check_eq("mix_occ", 32'(occupancy), 32'h3);

        // Reset with three channels full; the handshake this cycle is ignored.
        out_ready = 4'b0000;
        in_sel    = 2'd0;
        in_data   = 4'hF;
        rst       = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("mrst_valid", 32'(out_valid), 32'h0);
        check_eq("mrst_occ", 32'(occupancy), 32'h0);
        check_eq("mrst_ready", 32'(in_ready), 32'h1);
        check_eq("mrst_d0", 32'(out_data0), 32'h0);

`ifdef DEMUX_1_4_BROADCAST_EN
        in_valid = 1'b1;
        in_bcast = 1'b1;
        in_sel   = 2'd2;
        in_data  = 4'h9;
        #1;
        check_eq("bc_ready", 32'(in_ready), 32'h1);
        step();
        check_eq("bc_valid", 32'(out_valid), 32'hF);
        check_eq("bc_d0", 32'(out_data0), 32'h9);
        check_eq("bc_d1", 32'(out_data1), 32'h9);
        check_eq("bc_d2", 32'(out_data2), 32'h9);
        check_eq("bc_d3", 32'(out_data3), 32'h9);
        check_eq("bc_occ", 32'(occupancy), 32'h4);

        // Channel 3 stalled blocks a second broadcast.
        out_ready = 4'b0111;
        in_data   = 4'h2;
        #1;
        check_eq("bc_stall_ready", 32'(in_ready), 32'h0);
        step();
        check_eq("bc_stall_valid", 32'(out_valid), 32'h8);
        check_eq("bc_stall_d3", 32'(out_data3), 32'h9);
        check_eq("bc_stall_occ", 32'(occupancy), 32'h1);
        in_valid  = 1'b0;
        in_bcast  = 1'b0;
        out_ready = 4'b0000;
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
